// File: rtl/minesweeper_board_reader_if.sv
// Board reader bus bundle.
// Carries two links owned by the board reader:
//   - board RAM read port: rd_addr/rd_en out, rd_data back one cycle after rd_en
//   - tile stream to the renderer: tile_valid/tile_pos/tile_glyph/tile_cursor out,
//     tile_ready back; a tile moves when tile_valid && tile_ready
// rd_data bit map (MSB first): [6] bomb, [5] covered, [4] flagged, [3] queued,
// [2:0] adjacent-bomb count. A literal such as 7'b0100000 therefore reads
// left-to-right as bomb, covered, flagged, queued, count.
// Modports: master = board reader, slave = RAM/renderer side.
interface minesweeper_board_reader_if #(
   parameter int unsigned ADDR_W = 8
);
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_en;
   logic [6:0]        rd_data;
   logic              tile_valid;
   logic              tile_ready;
   logic [ADDR_W-1:0] tile_pos;
   logic [3:0]        tile_glyph;
   logic              tile_cursor;

   modport master (
      output rd_addr,
      output rd_en,
      input  rd_data,
      output tile_valid,
      input  tile_ready,
      output tile_pos,
      output tile_glyph,
      output tile_cursor
   );

   modport slave (
      input  rd_addr,
      input  rd_en,
      output rd_data,
      input  tile_valid,
      output tile_ready,
      input  tile_pos,
      input  tile_glyph,
      input  tile_cursor
   );
endinterface

// File: rtl/minesweeper_board_reader.sv
// Board reader: scans every board cell from RAM port B once per start pulse,
// decodes each cell into a display glyph and streams tiles to the renderer.
// Covered safe cells are tallied during the scan and published at scan end.
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous active-low reset
//   start          one-cycle scan request, honoured only when idle
//   cursorPosition cursor cell index, compared at read-issue time
//   gameOverState  00 playing, 01 won, 10 lost, 11 playing
//   bus            RAM read port + tile stream (master side)
//   busy           scan in progress (cycle after start until scan_done)
//   scan_done      one-cycle pulse after the final tile is accepted
//   safe_remaining covered safe cells counted by the last completed scan
module minesweeper_board_reader #(
   parameter int unsigned NUM_CELLS = 256,
   parameter int unsigned ADDR_W    = 8,
   parameter int unsigned CNT_W     = 9
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic [ADDR_W-1:0]          cursorPosition,
   input  logic [1:0]                 gameOverState,
   minesweeper_board_reader_if.master bus,
   output logic                       busy,
   output logic                       scan_done,
   output logic [CNT_W-1:0]           safe_remaining
);

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StScan  = 2'd1;
   localparam logic [1:0] StDrain = 2'd2;
   localparam logic [1:0] StDone  = 2'd3;

   localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NUM_CELLS - 1);
   // FIFO entry: {pos, cursor, glyph}
   localparam int unsigned EntryW = ADDR_W + 5;

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              inflight_q, inflight_d;
   logic [ADDR_W-1:0] rd_pos_q, rd_pos_d;
   logic              rd_cur_q, rd_cur_d;
   logic [1:0]        fifo_cnt_q, fifo_cnt_d;
   logic [EntryW-1:0] head_q, head_d;
   logic [EntryW-1:0] tail_q, tail_d;
   logic [CNT_W-1:0]  tally_q, tally_d;
   logic [CNT_W-1:0]  safe_q, safe_d;

   logic              issue;
   logic              push;
   logic              pop;
   logic              room;
   logic [2:0]        occ_after;
   logic              is_bomb, is_covered, is_flagged, is_lost;
   logic [2:0]        adj_cnt;
   logic [3:0]        glyph;
   logic [EntryW-1:0] new_entry;
   logic              unused_queued;

   assign is_bomb       = bus.rd_data[6];
   assign is_covered    = bus.rd_data[5];
   assign is_flagged    = bus.rd_data[4];
   assign unused_queued = bus.rd_data[3];
   assign adj_cnt       = bus.rd_data[2:0];
   assign is_lost       = (gameOverState == 2'b10);

   // Data on rd_data belongs to the read issued last cycle.
   assign push = inflight_q;
   assign pop  = (fifo_cnt_q != 2'd0) && bus.tile_ready;

   // Occupancy counts the tile leaving this cycle, so a held-high tile_ready
   // keeps one read in flight every cycle and the stream runs at full rate.
   assign occ_after = {1'b0, fifo_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
   assign room      = (occ_after < 3'd2);

   // Glyph decode, first match wins; game state is taken at push time.
   always_comb begin
      glyph = {1'b0, adj_cnt};
      if (is_flagged && is_covered && is_lost && !is_bomb) begin
         glyph = 4'd12;
      end else if (is_flagged && is_covered) begin
         glyph = 4'd10;
      end else if (is_covered && is_lost && is_bomb) begin
         glyph = 4'd11;
      end else if (is_covered) begin
         glyph = 4'd9;
      end else if (is_bomb) begin
         glyph = 4'd13;
      end
   end

   assign new_entry = {rd_pos_q, rd_cur_q, glyph};

   // Two-entry FIFO; head_q drives the tile outputs directly.
   always_comb begin
      fifo_cnt_d = fifo_cnt_q;
      head_d     = head_q;
      tail_d     = tail_q;
      unique case ({push, pop})
         2'b10: begin
            if (fifo_cnt_q == 2'd0) begin
               head_d = new_entry;
            end else begin
               tail_d = new_entry;
            end
            fifo_cnt_d = fifo_cnt_q + 2'd1;
         end
         2'b01: begin
            head_d     = tail_q;
            fifo_cnt_d = fifo_cnt_q - 2'd1;
         end
         2'b11: begin
            if (fifo_cnt_q == 2'd1) begin
               head_d = new_entry;
            end else begin
               head_d = tail_q;
               tail_d = new_entry;
            end
         end
         default: ;
      endcase
   end

   // Scan control. The first read goes out on the start cycle itself so the
   // first tile is presented two cycles after start.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      issue   = 1'b0;
      tally_d = tally_q;
      safe_d  = safe_q;
      if (push && is_covered && !is_bomb) begin
         tally_d = tally_q + CNT_W'(1);
      end
      case (state_q)
         StIdle: begin
            if (start) begin
               issue   = 1'b1;
               addr_d  = addr_q + ADDR_W'(1);
               tally_d = '0;
               state_d = StScan;
            end
         end
         StScan: begin
            if (room) begin
               issue = 1'b1;
               if (addr_q == LastAddr) begin
                  state_d = StDrain;
               end else begin
                  addr_d = addr_q + ADDR_W'(1);
               end
            end
         end
         StDrain: begin
            // No read outstanding means no push this cycle, so tally_q is final.
            if (!inflight_q && (fifo_cnt_d == 2'd0)) begin
               safe_d  = tally_q;
               state_d = StDone;
            end
         end
         StDone: begin
            addr_d  = '0;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign inflight_d = issue;
   assign rd_pos_d   = issue ? addr_q : rd_pos_q;
   assign rd_cur_d   = issue ? (addr_q == cursorPosition) : rd_cur_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= StIdle;
         addr_q     <= '0;
         inflight_q <= 1'b0;
         rd_pos_q   <= '0;
         rd_cur_q   <= 1'b0;
         fifo_cnt_q <= 2'd0;
         head_q     <= '0;
         tail_q     <= '0;
         tally_q    <= '0;
         safe_q     <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         inflight_q <= inflight_d;
         rd_pos_q   <= rd_pos_d;
         rd_cur_q   <= rd_cur_d;
         fifo_cnt_q <= fifo_cnt_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         tally_q    <= tally_d;
         safe_q     <= safe_d;
      end
   end

   assign bus.rd_addr     = addr_q;
   assign bus.rd_en       = issue;
   assign bus.tile_valid  = (fifo_cnt_q != 2'd0);
   assign bus.tile_pos    = head_q[EntryW-1:5];
   assign bus.tile_cursor = head_q[4];
   assign bus.tile_glyph  = head_q[3:0];
   assign busy            = (state_q == StScan) || (state_q == StDrain);
   assign scan_done       = (state_q == StDone);
   assign safe_remaining  = safe_q;

endmodule

// File: tb/tb_minesweeper_board_reader.sv
// Directed bench for minesweeper_board_reader: a behavioural board RAM answers
// reads one cycle late, tiles are captured as they are accepted and compared
// against hand-written glyph tables per board.
module tb_minesweeper_board_reader;

   logic       clk;
   logic       reset;
   logic       start;
   logic [7:0] cursor_pos;
   logic [1:0] game_over;
   logic       busy;
   logic       scan_done;
   logic [8:0] safe_remaining;

   minesweeper_board_reader_if #(.ADDR_W(8)) bif ();

   minesweeper_board_reader #(
      .NUM_CELLS(256),
      .ADDR_W   (8),
      .CNT_W    (9)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .cursorPosition(cursor_pos),
      .gameOverState (game_over),
      .bus           (bif),
      .busy          (busy),
      .scan_done     (scan_done),
      .safe_remaining(safe_remaining)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [6:0]  mem [256];
   logic [3:0]  eg  [256];
   logic [12:0] got [256];

   always @(posedge clk) begin
      if (bif.rd_en) bif.rd_data <= mem[bif.rd_addr];
   end

   int errors;
   int checks;
   int n_tiles, done_cyc, first_vc, gaps, stall_bad, max_occ;
   logic [8:0] done_safe;
   logic post_done, post_busy;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic fill_board(input logic [6:0] w, input logic [3:0] g);
      for (int i = 0; i < 256; i++) begin
         mem[i] = w;
         eg[i]  = g;
      end
   endtask

   // rmode 0: tile_ready held high, 1: tile_ready random 50%.
   task automatic run_scan(input int rmode, input int restart_at, input int abort_at,
                           input logic [8:0] hold_v);
      logic        pv, pr;
      logic [12:0] pt, cur;
      n_tiles = 0; done_cyc = -1; first_vc = -1; gaps = 0; stall_bad = 0; max_occ = 0;
      done_safe = '0; post_done = 1'b1; post_busy = 1'b1;
      @(negedge clk);
      start = 1'b1;
      bif.tile_ready = 1'b1;
      pv = 1'b0; pr = 1'b0; pt = '0;
      for (int c = 1; c < 3000; c++) begin
         @(negedge clk);
         start = (c == restart_at);
         bif.tile_ready = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         cur = {bif.tile_pos, bif.tile_cursor, bif.tile_glyph};
         if (c == 1) chk("busy_after_start", {31'd0, busy}, 32'd1);
         if (c == 100) chk("safe_held", {23'd0, safe_remaining}, {23'd0, hold_v});
         if (pv && !pr && !(bif.tile_valid && cur == pt)) stall_bad++;
         if (int'(dut.fifo_cnt_q) > max_occ) max_occ = int'(dut.fifo_cnt_q);
         if (bif.tile_valid && first_vc < 0) first_vc = c;
         if (rmode == 0 && c >= 2 && c <= 257 && !bif.tile_valid) gaps++;
         if (bif.tile_valid && bif.tile_ready) begin
            if (n_tiles < 256) got[n_tiles] = cur;
            n_tiles++;
         end
         if (scan_done) begin
            done_cyc  = c;
            done_safe = safe_remaining;
            break;
         end
         if (abort_at > 0 && n_tiles == abort_at) break;
         pv = bif.tile_valid; pr = bif.tile_ready; pt = cur;
      end
      if (done_cyc > 0) begin
         @(negedge clk);
         post_done = scan_done;
         post_busy = busy;
      end
   endtask

   task automatic check_scan(input string name, input int rmode, input int exp_done,
                             input logic [8:0] exp_safe);
      chk({name, ":tile_count"}, n_tiles, 256);
      for (int i = 0; i < 256; i++) begin
         chk($sformatf("%s:tile%0d", name, i), {19'd0, got[i]},
             {19'd0, 8'(i), (8'(i) == cursor_pos), eg[i]});
      end
      chk({name, ":first_valid_cycle"}, first_vc, 2);
      chk({name, ":done_seen"}, {31'd0, done_cyc > 0}, 32'd1);
      if (exp_done > 0) chk({name, ":done_cycle"}, done_cyc, exp_done);
      chk({name, ":safe_remaining"}, {23'd0, done_safe}, {23'd0, exp_safe});
      chk({name, ":done_one_cycle"}, {31'd0, post_done}, 32'd0);
      chk({name, ":busy_after_done"}, {31'd0, post_busy}, 32'd0);
      chk({name, ":stall_stable"}, stall_bad, 0);
      chk({name, ":fifo_le2"}, {31'd0, max_occ <= 2}, 32'd1);
      if (rmode == 0) chk({name, ":no_gaps"}, gaps, 0);
   endtask

   task automatic check_reset_outputs(input string name);
      chk({name, ":tile_valid"}, {31'd0, bif.tile_valid}, 32'd0);
      chk({name, ":tile_pos"}, {24'd0, bif.tile_pos}, 32'd0);
      chk({name, ":tile_glyph"}, {28'd0, bif.tile_glyph}, 32'd0);
      chk({name, ":tile_cursor"}, {31'd0, bif.tile_cursor}, 32'd0);
      chk({name, ":rd_en"}, {31'd0, bif.rd_en}, 32'd0);
      chk({name, ":busy"}, {31'd0, busy}, 32'd0);
      chk({name, ":scan_done"}, {31'd0, scan_done}, 32'd0);
      chk({name, ":safe_remaining"}, {23'd0, safe_remaining}, 32'd0);
   endtask

   task automatic mixed_board();
      fill_board(7'b0100000, 4'd9);
      mem[5]   = 7'b1100000;  // covered bomb
      mem[6]   = 7'b0110000;  // flagged covered safe
      mem[7]   = 7'b0000011;  // uncovered, 3 neighbours
      mem[8]   = 7'b1000000;  // uncovered bomb
      mem[9]   = 7'b1110000;  // flagged covered bomb
      mem[10]  = 7'b0000111;  // uncovered, 7 neighbours
      mem[200] = 7'b0101000;  // covered safe, queued bit set
      eg[7] = 4'd3; eg[8] = 4'd13; eg[10] = 4'd7;
   endtask

   initial begin
      errors = 0;
      checks = 0;
      reset = 1'b0;
      start = 1'b0;
      cursor_pos = 8'd17;
      game_over = 2'b00;
      bif.tile_ready = 1'b0;
      bif.rd_data = '0;
      #1;
      check_reset_outputs("reset");
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      // All covered safe cells, full-rate stream.
      fill_board(7'b0100000, 4'd9);
      run_scan(0, 0, 0, 9'd0);
      check_scan("all_covered", 0, 258, 9'd256);

      // Lost game, random back-pressure, start re-pulsed mid-scan.
      mixed_board();
      eg[5] = 4'd11; eg[6] = 4'd12; eg[9] = 4'd10;
      game_over = 2'b10;
      run_scan(1, 50, 0, 9'd256);
      check_scan("lost_random", 1, 0, 9'd251);

      // Same board, state 11 behaves as playing.
      eg[5] = 4'd9; eg[6] = 4'd10; eg[9] = 4'd10;
      game_over = 2'b11;
      run_scan(0, 0, 0, 9'd251);
      check_scan("playing", 0, 258, 9'd251);

      // Abort mid-scan with reset.
      game_over = 2'b00;
      run_scan(0, 0, 100, 9'd251);
      chk("abort:reached_tile100", n_tiles, 100);
      reset = 1'b0;
      #1;
      check_reset_outputs("abort");
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      begin
         int stray_done;
         stray_done = 0;
         for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (scan_done || busy) stray_done++;
         end
         chk("abort:no_scan_done", stray_done, 0);
      end

      // Rescan after abort starts again from cell 0.
      run_scan(0, 0, 0, 9'd0);
      check_scan("rescan", 0, 258, 9'd251);

      // 40 covered bombs, 216 uncovered safe cells.
      fill_board(7'b0000010, 4'd2);
      for (int i = 0; i < 40; i++) begin
         mem[i] = 7'b1100000;
         eg[i]  = 4'd9;
      end
      run_scan(0, 0, 0, 9'd251);
      check_scan("bombs", 0, 258, 9'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
